// File: rtl/txn_responder.sv
// rtl/txn_responder.sv - in-order request/response responder with opcode transform
// Requests queue in a FIFO; the head is transformed, held for RSP_DELAY cycles, then presented.
module txn_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 4,
  parameter int RSP_DELAY  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ID_WIDTH-1:0]   req_id,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [15:0]           req_count,
  output logic [15:0]           rsp_count,
  output logic [15:0]           err_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] DELAY_INIT = 8'(RSP_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT} state_t;

  logic [1:0]            op_mem   [DEPTH];
  logic [ID_WIDTH-1:0]   id_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  state_t                state_q;
  logic                  live_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            delay_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [15:0]           req_count_q, rsp_count_q, err_count_q;

  logic                  push, pop;
  logic [PW-1:0]         rd_next, load_ptr;
  logic [ID_WIDTH-1:0]   load_id;
  logic [DATA_WIDTH:0]   load_rsp;

  function automatic logic [DATA_WIDTH:0] xform(input logic [1:0] op,
                                                input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH:0] r;
    case (op)
      2'd0:    r = {1'b0, d};
      2'd1:    r = {1'b0, ~d};
      2'd2:    r = {1'b0, d + DATA_WIDTH'(1)};
      default: r = {1'b1, {DATA_WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  // live_q keeps req_ready low until the first edge out of reset
  assign req_ready = live_q && (count_q != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid_q && rsp_ready;
  assign rd_next   = rd_ptr_q + 1'b1;

  // While presenting, the entry to load next sits one past the head being popped
  assign load_ptr  = (state_q == S_PRESENT) ? rd_next : rd_ptr_q;
  assign load_id   = id_mem[load_ptr];
  assign load_rsp  = xform(op_mem[load_ptr], data_mem[load_ptr]);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q]   <= req_op;
      id_mem[wr_ptr_q]   <= req_id;
      data_mem[wr_ptr_q] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      delay_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      req_count_q <= '0;
      rsp_count_q <= '0;
      err_count_q <= '0;
    end else begin
      live_q  <= 1'b1;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q    <= wr_ptr_q + 1'b1;
        req_count_q <= req_count_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_q    <= rd_next;
        rsp_count_q <= rsp_count_q + 16'd1;
        if (rsp_err_q) err_count_q <= err_count_q + 16'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            if (RSP_DELAY == 0) begin
              state_q     <= S_PRESENT;
              rsp_valid_q <= 1'b1;
              rsp_id_q    <= load_id;
              rsp_data_q  <= load_rsp[DATA_WIDTH-1:0];
              rsp_err_q   <= load_rsp[DATA_WIDTH];
            end else begin
              state_q <= S_WAIT;
              delay_q <= DELAY_INIT;
            end
          end
        end
        S_WAIT: begin
          if (delay_q <= 8'd1) begin
            state_q     <= S_PRESENT;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= load_id;
            rsp_data_q  <= load_rsp[DATA_WIDTH-1:0];
            rsp_err_q   <= load_rsp[DATA_WIDTH];
          end else begin
            delay_q <= delay_q - 8'd1;
          end
        end
        S_PRESENT: begin
          if (pop) begin
            if (count_q > CW'(1) && RSP_DELAY == 0) begin
              rsp_id_q   <= load_id;
              rsp_data_q <= load_rsp[DATA_WIDTH-1:0];
              rsp_err_q  <= load_rsp[DATA_WIDTH];
            end else begin
              rsp_valid_q <= 1'b0;
              rsp_id_q    <= '0;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b0;
              if (count_q > CW'(1)) begin
                state_q <= S_WAIT;
                delay_q <= DELAY_INIT;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign req_count = req_count_q;
  assign rsp_count = rsp_count_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_txn_responder.sv
// tb/tb_txn_responder.sv - directed self-checking bench for txn_responder
// Instance 0 uses RSP_DELAY=2, instance 1 uses RSP_DELAY=0; both share clock and reset.
module tb_txn_responder;
  localparam int D2 = 0;
  localparam int D0 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           req_valid, rsp_ready;
  logic [1:0][1:0]      req_op;
  logic [1:0][3:0]      req_id;
  logic [1:0][31:0]     req_data;
  wire  [1:0]           req_ready, rsp_valid, rsp_err;
  wire  [1:0][3:0]      rsp_id;
  wire  [1:0][31:0]     rsp_data;
  wire  [1:0][15:0]     req_count, rsp_count, err_count;

  int vectors;
  int miscompares;

  txn_responder #(.DATA_WIDTH(32), .ID_WIDTH(4), .DEPTH(4), .RSP_DELAY(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_id(req_id[0]), .req_data(req_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .req_count(req_count[0]), .rsp_count(rsp_count[0]), .err_count(err_count[0])
  );

  txn_responder #(.DATA_WIDTH(32), .ID_WIDTH(4), .DEPTH(4), .RSP_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_id(req_id[1]), .req_data(req_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .req_count(req_count[1]), .rsp_count(rsp_count[1]), .err_count(err_count[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid = '0;
    rsp_ready = '0;
    req_op    = '0;
    req_id    = '0;
    req_data  = '0;
  endtask

  task automatic push(input int d, input logic [1:0] op, input logic [3:0] id,
                      input logic [31:0] data, output bit ok);
    ok = 1'b0;
    req_valid[d] = 1'b1;
    req_op[d]    = op;
    req_id[d]    = id;
    req_data[d]  = data;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (req_ready[d]) ok = 1'b1;
      tick();
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic pop(input int d, output logic [3:0] id, output logic [31:0] data,
                     output logic err, output bit ok);
    ok = 1'b0;
    id = '0;
    data = '0;
    err = 1'b0;
    rsp_ready[d] = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (rsp_valid[d]) begin
        ok = 1'b1;
        id = rsp_id[d];
        data = rsp_data[d];
        err = rsp_err[d];
      end
      tick();
    end
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({rsp_valid[d], rsp_err[d], rsp_id[d], rsp_data[d]} !== 38'd0) begin
        miscompares++;
        $display("FAIL reset_rsp[%0d]: got v=%b e=%b id=%0h data=%h want all 0",
                 d, rsp_valid[d], rsp_err[d], rsp_id[d], rsp_data[d]);
      end
      vectors++;
      if ({req_count[d], rsp_count[d], err_count[d]} !== 48'd0) begin
        miscompares++;
        $display("FAIL reset_counts[%0d]: got %0d/%0d/%0d want 0/0/0",
                 d, req_count[d], rsp_count[d], err_count[d]);
      end
      vectors++;
      if (req_ready[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_req_ready[%0d]: got %b want 0", d, req_ready[d]);
      end
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (req_ready[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL post_reset_req_ready[%0d]: got %b want 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_single_echo;
    rsp_ready[D2] = 1'b1;
    req_valid[D2] = 1'b1;
    req_op[D2]    = 2'd0;
    req_id[D2]    = 4'd3;
    req_data[D2]  = 32'h1234_5678;
    vectors++;
    if (req_ready[D2] !== 1'b1) begin
      miscompares++;
      $display("FAIL echo_req_ready: got %b want 1", req_ready[D2]);
    end
    tick();
    req_valid[D2] = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) tick();
      vectors++;
      if (rsp_valid[D2] !== (c == 3)) begin
        miscompares++;
        $display("FAIL echo_latency N+%0d: got rsp_valid=%b want %b", c, rsp_valid[D2], c == 3);
      end
    end
    vectors++;
    if (rsp_id[D2] !== 4'd3 || rsp_data[D2] !== 32'h1234_5678 || rsp_err[D2] !== 1'b0) begin
      miscompares++;
      $display("FAIL echo_rsp: got id=%0h data=%h err=%b want id=3 data=12345678 err=0",
               rsp_id[D2], rsp_data[D2], rsp_err[D2]);
    end
    tick();
    vectors++;
    if (rsp_valid[D2] !== 1'b0 || rsp_id[D2] !== 4'd0 || rsp_data[D2] !== 32'd0) begin
      miscompares++;
      $display("FAIL echo_after_hs: got v=%b id=%0h data=%h want 0/0/0",
               rsp_valid[D2], rsp_id[D2], rsp_data[D2]);
    end
    vectors++;
    if (req_count[D2] !== 16'd1 || rsp_count[D2] !== 16'd1) begin
      miscompares++;
      $display("FAIL echo_counts: got req=%0d rsp=%0d want 1/1", req_count[D2], rsp_count[D2]);
    end
    rsp_ready[D2] = 1'b0;
  endtask

  task automatic test_ops;
    logic [1:0]  ops  [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] din  [3] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    logic [31:0] dexp [3] = '{32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000};
    logic        eexp [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0]  id;
    logic [31:0] data;
    logic        err;
    bit          ok1, ok2;
    for (int i = 0; i < 3; i++) begin
      push(D2, ops[i], 4'(5 + i), din[i], ok1);
      pop(D2, id, data, err, ok2);
      vectors++;
      if (!ok1 || !ok2 || id !== 4'(5 + i) || data !== dexp[i] || err !== eexp[i]) begin
        miscompares++;
        $display("FAIL ops[%0d]: got ok=%b%b id=%0h data=%h err=%b want id=%0h data=%h err=%b",
                 i, ok1, ok2, id, data, err, 4'(5 + i), dexp[i], eexp[i]);
      end
    end
    vectors++;
    if (err_count[D2] !== 16'd1 || rsp_count[D2] !== 16'd4 || req_count[D2] !== 16'd4) begin
      miscompares++;
      $display("FAIL ops_counts: got err=%0d rsp=%0d req=%0d want 1/4/4",
               err_count[D2], rsp_count[D2], req_count[D2]);
    end
  endtask

  task automatic test_backpressure;
    int  k = 0;
    int  j = 0;
    bit  seen = 0;
    bit  dropped = 0;
    bit  fire_req, fire_rsp;
    rsp_ready[D2] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      req_valid[D2] = (k < 6);
      req_op[D2]    = 2'd0;
      req_id[D2]    = 4'(k);
      req_data[D2]  = 32'hA5A5_0000 + 32'(k);
      fire_req = req_valid[D2] && req_ready[D2];
      if (rsp_valid[D2]) seen = 1;
      else if (seen) dropped = 1;
      tick();
      if (fire_req) k++;
    end
    vectors++;
    if (k != 4 || req_ready[D2] !== 1'b0 || req_count[D2] !== 16'd8) begin
      miscompares++;
      $display("FAIL bp_full: got accepted=%0d req_ready=%b req_count=%0d want 4/0/8",
               k, req_ready[D2], req_count[D2]);
    end
    vectors++;
    if (rsp_valid[D2] !== 1'b1 || dropped || rsp_id[D2] !== 4'd0 || rsp_data[D2] !== 32'hA5A5_0000) begin
      miscompares++;
      $display("FAIL bp_head_hold: got v=%b dropped=%b id=%0h data=%h want 1/0/0/a5a50000",
               rsp_valid[D2], dropped, rsp_id[D2], rsp_data[D2]);
    end
    rsp_ready[D2] = 1'b1;
    for (int c = 0; c < 80 && j < 6; c++) begin
      req_valid[D2] = (k < 6);
      req_id[D2]    = 4'(k);
      req_data[D2]  = 32'hA5A5_0000 + 32'(k);
      fire_req = req_valid[D2] && req_ready[D2];
      fire_rsp = rsp_valid[D2] && rsp_ready[D2];
      if (fire_rsp) begin
        vectors++;
        if (rsp_id[D2] !== 4'(j) || rsp_data[D2] !== 32'hA5A5_0000 + 32'(j) || rsp_err[D2] !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_order[%0d]: got id=%0h data=%h err=%b want id=%0h data=%h err=0",
                   j, rsp_id[D2], rsp_data[D2], rsp_err[D2], 4'(j), 32'hA5A5_0000 + 32'(j));
        end
        j++;
      end
      tick();
      if (fire_req) k++;
    end
    req_valid[D2] = 1'b0;
    rsp_ready[D2] = 1'b0;
    tick();
    vectors++;
    if (j != 6 || k != 6 || rsp_count[D2] !== 16'd10 || req_count[D2] !== 16'd10 || rsp_valid[D2] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got rsps=%0d reqs=%0d rsp_count=%0d req_count=%0d v=%b want 6/6/10/10/0",
               j, k, rsp_count[D2], req_count[D2], rsp_valid[D2]);
    end
  endtask

  task automatic test_back_to_back;
    int  k = 0;
    int  j = 0;
    int  gaps = 0;
    bit  ok;
    bit  all_ok = 1;
    bit  fire_req, fire_rsp;
    rsp_ready[D0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(D0, 2'd1, 4'(i), 32'h3C00_0000 + 32'(i), ok);
      all_ok &= ok;
    end
    k = 4;
    vectors++;
    if (!all_ok || req_ready[D0] !== 1'b0 || rsp_valid[D0] !== 1'b1 || rsp_id[D0] !== 4'd0) begin
      miscompares++;
      $display("FAIL b2b_full: got ok=%b req_ready=%b v=%b id=%0h want 1/0/1/0",
               all_ok, req_ready[D0], rsp_valid[D0], rsp_id[D0]);
    end
    rsp_ready[D0] = 1'b1;
    for (int c = 0; c < 80 && j < 12; c++) begin
      req_valid[D0] = (k < 12);
      req_op[D0]    = 2'd1;
      req_id[D0]    = 4'(k);
      req_data[D0]  = 32'h3C00_0000 + 32'(k);
      fire_req = req_valid[D0] && req_ready[D0];
      fire_rsp = rsp_valid[D0] && rsp_ready[D0];
      if (fire_rsp) begin
        if (j == 0) begin
          vectors++;
          if (req_ready[D0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_pop_at_full: got req_ready=%b want 0", req_ready[D0]);
          end
        end
        vectors++;
        if (rsp_id[D0] !== 4'(j) || rsp_data[D0] !== ~(32'h3C00_0000 + 32'(j)) || rsp_err[D0] !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_rsp[%0d]: got id=%0h data=%h err=%b want id=%0h data=%h err=0",
                   j, rsp_id[D0], rsp_data[D0], rsp_err[D0], 4'(j), ~(32'h3C00_0000 + 32'(j)));
        end
        j++;
      end else if (j > 0) begin
        gaps++;
      end
      tick();
      if (fire_req) k++;
    end
    req_valid[D0] = 1'b0;
    rsp_ready[D0] = 1'b0;
    vectors++;
    if (j != 12 || k != 12 || gaps != 0) begin
      miscompares++;
      $display("FAIL b2b_stream: got rsps=%0d reqs=%0d gaps=%0d want 12/12/0", j, k, gaps);
    end
    tick();
    vectors++;
    if (req_count[D0] !== 16'd12 || rsp_count[D0] !== 16'd12 || rsp_valid[D0] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_counts: got req=%0d rsp=%0d v=%b want 12/12/0",
               req_count[D0], rsp_count[D0], rsp_valid[D0]);
    end
  endtask

  task automatic test_reset_mid;
    bit          ok, ok2;
    bit          all_ok = 1;
    int          stale = 0;
    logic [3:0]  id;
    logic [31:0] data;
    logic        err;
    rsp_ready[D2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(D2, 2'd0, 4'(i), 32'hBB00_0000 + 32'(i), ok);
      all_ok &= ok;
    end
    for (int i = 0; i < 10 && !rsp_valid[D2]; i++) tick();
    vectors++;
    if (!all_ok || rsp_valid[D2] !== 1'b1 || req_ready[D2] !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_setup: got ok=%b v=%b req_ready=%b want 1/1/0",
               all_ok, rsp_valid[D2], req_ready[D2]);
    end
    rst_n = 1'b0;
    rsp_ready[D2] = 1'b1;
    req_valid[D2] = 1'b1;
    req_id[D2]    = 4'd8;
    req_data[D2]  = 32'h7777_7777;
    tick();
    vectors++;
    if ({rsp_valid[D2], rsp_err[D2], rsp_id[D2], rsp_data[D2], req_ready[D2]} !== 39'd0) begin
      miscompares++;
      $display("FAIL rmid_outputs: got v=%b e=%b id=%0h data=%h req_ready=%b want all 0",
               rsp_valid[D2], rsp_err[D2], rsp_id[D2], rsp_data[D2], req_ready[D2]);
    end
    vectors++;
    if ({req_count[D2], rsp_count[D2], err_count[D2]} !== 48'd0) begin
      miscompares++;
      $display("FAIL rmid_counts: got %0d/%0d/%0d want 0/0/0",
               req_count[D2], rsp_count[D2], err_count[D2]);
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();
    push(D2, 2'd0, 4'd9, 32'h0F0F_1234, ok);
    pop(D2, id, data, err, ok2);
    vectors++;
    if (!ok || !ok2 || id !== 4'd9 || data !== 32'h0F0F_1234 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_fresh: got ok=%b%b id=%0h data=%h err=%b want id=9 data=0f0f1234 err=0",
               ok, ok2, id, data, err);
    end
    rsp_ready[D2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid[D2]) stale++;
      tick();
    end
    rsp_ready[D2] = 1'b0;
    vectors++;
    if (stale != 0 || req_count[D2] !== 16'd1 || rsp_count[D2] !== 16'd1) begin
      miscompares++;
      $display("FAIL rmid_stale: got stale=%0d req=%0d rsp=%0d want 0/1/1",
               stale, req_count[D2], rsp_count[D2]);
    end
  endtask

  task automatic test_counter_wrap;
    localparam int N = 65537;
    int  k = 0;
    int  j = 0;
    bit  fire_req, fire_rsp;
    logic [31:0] exp_data;
    rsp_ready[D0] = 1'b1;
    for (int c = 0; c < 70000 && j < N; c++) begin
      req_valid[D0] = (k < N);
      req_op[D0]    = 2'd0;
      req_id[D0]    = 4'(k);
      req_data[D0]  = 32'(k) * 32'h9E37_79B9 + 32'd7;
      fire_req = req_valid[D0] && req_ready[D0];
      fire_rsp = rsp_valid[D0] && rsp_ready[D0];
      if (fire_rsp) begin
        exp_data = 32'(j) * 32'h9E37_79B9 + 32'd7;
        vectors++;
        if (rsp_id[D0] !== 4'(j) || rsp_data[D0] !== exp_data || rsp_err[D0] !== 1'b0) begin
          miscompares++;
          $display("FAIL wrap_rsp[%0d]: got id=%0h data=%h err=%b want id=%0h data=%h err=0",
                   j, rsp_id[D0], rsp_data[D0], rsp_err[D0], 4'(j), exp_data);
        end
        j++;
      end
      tick();
      if (fire_req) k++;
    end
    req_valid[D0] = 1'b0;
    rsp_ready[D0] = 1'b0;
    tick();
    vectors++;
    if (j != N || k != N) begin
      miscompares++;
      $display("FAIL wrap_done: got rsps=%0d reqs=%0d want %0d", j, k, N);
    end
    vectors++;
    if (req_count[D0] !== 16'd1 || rsp_count[D0] !== 16'd1 || err_count[D0] !== 16'd0) begin
      miscompares++;
      $display("FAIL wrap_counts: got req=%0d rsp=%0d err=%0d want 1/1/0",
               req_count[D0], rsp_count[D0], err_count[D0]);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_single_echo();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
